arb_request_queue: RTL and testbench
====================================

Name: arb_request_queue

Overview:
Per-requester input queueing stage upstream of the round_robin / prioritized_round_robin arbiter. Each of REQUEST_WIDTH ports gets a FIFO, and each port's request line is driven from its FIFO occupancy. The block consumes the arbiter's one-hot grant, pops the granted entry into a single output register, and presents it downstream with valid/ready plus the source index.

Parameters:
REQUEST_WIDTH, 8, number of requester ports; matches the arbiter's REQUEST_WIDTH
DATA_WIDTH, 16, payload bits per entry
DEPTH, 4, entries per port FIFO; power of two, >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
i_valid  input  REQUEST_WIDTH  per-port push valid
o_ready  output  REQUEST_WIDTH  per-port push ready
i_data  input  REQUEST_WIDTH x DATA_WIDTH  per-port push payload, packed [REQUEST_WIDTH-1:0][DATA_WIDTH-1:0]
o_request  output  REQUEST_WIDTH  to arbiter i_request
i_grant  input  REQUEST_WIDTH  from arbiter o_grant, one-hot or zero
o_valid  output  1  output register holds data
i_ready  input  1  downstream accepts
o_data  output  DATA_WIDTH  output payload
o_source  output  $clog2(REQUEST_WIDTH)  port index of o_data

Behaviour:
- Reset (async, rst_n low): all FIFOs empty, pointers 0.
  - Outputs during reset: o_ready = all 1, o_request = 0, o_valid = 0, o_data = 0, o_source = 0.
  - Reset mid-operation discards all queued and output data; no partial state survives.
- Per-port FIFO state:
  - rd/wr pointers of $clog2(DEPTH)+1 bits; count = wr - rd (modulo); full when count == DEPTH.
- Push:
  - Occurs when i_valid[i] && o_ready[i].
  - o_ready[i] = !full[i], registered state only; no combinational dependence on pop.
  - A full FIFO rejects a push even in a cycle where it is popped.
- Output slot:
  - slot_free = !o_valid || i_ready.
- Request:
  - o_request[i] = (count[i] != 0) && slot_free.
  - Data pushed in cycle N is visible on o_request no earlier than cycle N+1 (one-cycle push-to-request latency).
- Pop:
  - Occurs when i_grant[i] && o_request[i].
  - Head entry loads the output register at the clock edge: o_valid=1, o_data=head, o_source=i, rd[i]++.
- Output handshake:
  - Entry transfers when o_valid && i_ready.
  - Transfer without a same-cycle pop: o_valid=0 next cycle.
  - Transfer with a same-cycle pop: the register reloads, allowing back-to-back one entry per cycle.
- o_data/o_source stable while o_valid && !i_ready.
- Illegal grants:
  - Grant bits on ports with o_request=0 are ignored.
  - If multiple grant bits qualify, the lowest index pops; other ports are unchanged.
- Simultaneous push and pop on the same non-full port: both take effect; count unchanged.
- Pointer wrap-around is natural modulo 2*DEPTH; no special handling.
- Ordering: FIFO order per port; no ordering guarantee across ports beyond grant order.

Optional Feature:
Macro ARB_REQUEST_QUEUE_CHECK_EN.
- Defined:
  - Adds output o_error (1 bit, reset 0).
  - o_error is sticky and set on any cycle where i_grant is non-one-hot-or-zero, or i_grant has a bit set where o_request is 0.
  - Cleared only by rst_n.
  - Adds an assertion that fires on the same condition.
- Not defined: no o_error port, no assertion; illegal grants are handled only as described in Behaviour.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> o_ready=8'hFF, o_request=0, o_valid=0, o_data=0 throughout; no change with i_valid=0.
- Single port: push 16'hA5A5 on port 3 at cycle N, arbiter grants -> o_request=8'h08 at N+1; o_valid=1, o_data=16'hA5A5, o_source=3 after the grant edge; i_ready=1 -> o_valid=0 next cycle.
- Full/backpressure: push 5 entries on port 0 with i_ready=0 and no grant -> o_ready[0]=0 after the 4th push, 5th not accepted; o_request=0 while o_valid=1 and i_ready=0.
- Round-robin drain: ports 0..7 each push 2 entries (data = port*16+k), i_ready=1, round_robin arbiter attached -> 16 outputs, one per cycle back-to-back once started, each port's two entries in order, o_source matching data[7:4].
- Wrap-around and simultaneous push/pop: port 5 streams 64 entries with a continuous grant -> all 64 arrive in order, count never exceeds 4, no loss across pointer wraps.
- Reset mid-operation: 3 entries queued on port 2 with o_valid=1, then pulse rst_n low -> o_valid=0, o_request=0 immediately; after release no stale data appears.
- With ARB_REQUEST_QUEUE_CHECK_EN: force i_grant=8'h03 -> o_error=1 next cycle and held until reset.

Source files
------------

// File: rtl/arb_request_queue.sv
// arb_request_queue
// Per-requester FIFO queueing in front of a round-robin style arbiter. Each
// port's request line reflects its FIFO occupancy. The one-hot grant pops the
// granted head into a single output register, which is presented downstream
// with valid/ready and the source port index.
// Optional build macro: ARB_REQUEST_QUEUE_CHECK_EN adds a sticky o_error flag
// and an assertion for illegal grants (multi-hot, or granting a non-requester).
module arb_request_queue #(
    parameter int REQUEST_WIDTH = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [REQUEST_WIDTH-1:0]                 i_valid,
    output logic [REQUEST_WIDTH-1:0]                 o_ready,
    input  logic [REQUEST_WIDTH-1:0][DATA_WIDTH-1:0] i_data,
    output logic [REQUEST_WIDTH-1:0]                 o_request,
    input  logic [REQUEST_WIDTH-1:0]                 i_grant,
    output logic                                     o_valid,
    input  logic                                     i_ready,
    output logic [DATA_WIDTH-1:0]                    o_data,
    output logic [$clog2(REQUEST_WIDTH)-1:0]         o_source
`ifdef ARB_REQUEST_QUEUE_CHECK_EN
    ,
    output logic                                     o_error
`endif
);

    localparam int SRC_W  = $clog2(REQUEST_WIDTH);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // Storage and pointers. Pointers carry one extra wrap bit so that
    // full and empty are distinguishable; wrap-around is plain modulo.
    logic [DATA_WIDTH-1:0]    mem    [REQUEST_WIDTH][DEPTH];
    logic [PTR_W-1:0]         wr_ptr [REQUEST_WIDTH];
    logic [PTR_W-1:0]         rd_ptr [REQUEST_WIDTH];
    logic [PTR_W-1:0]         count  [REQUEST_WIDTH];

    logic [REQUEST_WIDTH-1:0] push;
    logic [REQUEST_WIDTH-1:0] pop;
    logic [REQUEST_WIDTH-1:0] nonempty;
    logic                     slot_free;
    logic                     pop_any;
    logic [SRC_W-1:0]         pop_idx;
    logic [DATA_WIDTH-1:0]    pop_data;

    // Occupancy, push-side ready and accepted pushes, from registered pointers only.
    always_comb begin
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            count[i]    = wr_ptr[i] - rd_ptr[i];
            o_ready[i]  = (count[i] != PTR_W'(DEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = i_valid[i] && o_ready[i];
        end
    end

    // The output register can take a new entry if it is empty or draining now.
    assign slot_free = !o_valid || i_ready;
    assign o_request = nonempty & {REQUEST_WIDTH{slot_free}};

    // Qualify the grant against our requests; lowest qualifying index wins.
    always_comb begin
        pop     = '0;
        pop_any = 1'b0;
        pop_idx = '0;
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (i_grant[i] && o_request[i] && !pop_any) begin
                pop[i]  = 1'b1;
                pop_any = 1'b1;
                pop_idx = SRC_W'(i);
            end
        end
    end

    assign pop_data = mem[pop_idx][rd_ptr[pop_idx][ADDR_W-1:0]];

    // Pointer update: push and pop on the same port both advance independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQUEST_WIDTH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQUEST_WIDTH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][ADDR_W-1:0]] <= i_data[i];
            end
        end
    end

    // Output register: load on pop, clear on transfer without a reload, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_source <= '0;
        end else if (pop_any) begin
            o_valid  <= 1'b1;
            o_data   <= pop_data;
            o_source <= pop_idx;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end

`ifdef ARB_REQUEST_QUEUE_CHECK_EN
    logic grant_illegal;

    assign grant_illegal = (|(i_grant & (i_grant - REQUEST_WIDTH'(1))))
                        || (|(i_grant & ~o_request));

    // Sticky illegal-grant flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_error <= 1'b0;
        end else if (grant_illegal) begin
            o_error <= 1'b1;
        end
    end

    a_grant_legal: assert property (@(posedge clk) disable iff (!rst_n) !grant_illegal);
`endif

endmodule

// File: tb/tb_arb_request_queue.sv
// Testbench for arb_request_queue: randomized and directed stimulus checked
// against a queue-based reference model, with a scoreboard of expected
// outputs consumed by an independent monitor.
module tb_arb_request_queue;

    localparam int RW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic                   clk     = 1'b0;
    logic                   rst_n   = 1'b1;
    logic [RW-1:0]          i_valid = '0;
    logic [RW-1:0]          o_ready;
    logic [RW-1:0][DW-1:0]  i_data  = '0;
    logic [RW-1:0]          o_request;
    logic [RW-1:0]          i_grant = '0;
    logic                   o_valid;
    logic                   i_ready = 1'b0;
    logic [DW-1:0]          o_data;
    logic [2:0]             o_source;
`ifdef ARB_REQUEST_QUEUE_CHECK_EN
    logic                   o_error;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per port, the output slot valid bit, and a
    // scoreboard of {source, data} expected downstream in order.
    logic [DW-1:0]          mq [RW][$];
    logic [DW+2:0]          sb [$];
    logic                   m_valid = 1'b0;
    int                     rr_ptr  = 0;

    logic [RW-1:0]          acc;
    logic [RW-1:0][DW-1:0]  d;

    always #5 clk = ~clk;

    arb_request_queue #(
        .REQUEST_WIDTH(RW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .o_request(o_request),
        .i_grant  (i_grant),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_source (o_source)
`ifdef ARB_REQUEST_QUEUE_CHECK_EN
        ,
        .o_error  (o_error)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every downstream transfer must match the oldest expected entry.
    initial begin
        logic [DW+2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && o_valid === 1'b1 && i_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got src %0d data %h, required no output (t=%0t)",
                             o_source, o_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(o_data), 32'(e[DW-1:0]));
                    chk("out_source", 32'(o_source), 32'(e[DW+2:DW]));
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_o_ready"},   32'(o_ready),   32'(8'hFF));
        chk({tag, "_o_request"}, 32'(o_request), 32'd0);
        chk({tag, "_o_valid"},   32'(o_valid),   32'd0);
        chk({tag, "_o_data"},    32'(o_data),    32'd0);
        chk({tag, "_o_source"},  32'(o_source),  32'd0);
`ifdef ARB_REQUEST_QUEUE_CHECK_EN
        chk({tag, "_o_error"},   32'(o_error),   32'd0);
`endif
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n   = 1'b0;
        i_valid = '0;
        i_grant = '0;
        i_ready = 1'b0;
        #1;
        chk_reset_outputs("rst_now");
        for (int i = 0; i < RW; i++) mq[i].delete();
        sb.delete();
        m_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive push/ready after the edge, check the model's
    // view of ready/request/valid, pick a grant, then advance the model.
    // gmode: 0 none, 1 fixed, 2 round-robin, 3 random legal, 4 random bits.
    task automatic step(input logic [RW-1:0] v, input logic [RW-1:0][DW-1:0] dd,
                        input logic rdy, input int gmode, input logic [RW-1:0] gfix,
                        output logic [RW-1:0] accepted);
        logic [RW-1:0] e_rdy, e_req, g;
        logic          slot;
        int            pidx, idx, start;
        @(posedge clk);
        #1;
        i_valid = v;
        i_data  = dd;
        i_ready = rdy;
        i_grant = '0;
        @(negedge clk);
        slot = !m_valid || rdy;
        for (int i = 0; i < RW; i++) begin
            e_rdy[i] = (mq[i].size() < DEPTH);
            e_req[i] = (mq[i].size() != 0) && slot;
        end
        chk("o_ready",   32'(o_ready),   32'(e_rdy));
        chk("o_request", 32'(o_request), 32'(e_req));
        chk("o_valid",   32'(o_valid),   32'(m_valid));
        g = '0;
        case (gmode)
            1: g = gfix;
            2: begin
                for (int k = 0; k < RW; k++) begin
                    idx = (rr_ptr + k) % RW;
                    if (g == '0 && e_req[idx]) begin
                        g[idx] = 1'b1;
                        rr_ptr = (idx + 1) % RW;
                    end
                end
            end
            3: begin
                start = $urandom_range(0, RW - 1);
                for (int k = 0; k < RW; k++) begin
                    idx = (start + k) % RW;
                    if (g == '0 && e_req[idx]) g[idx] = 1'b1;
                end
            end
            4: g = RW'($urandom);
            default: g = '0;
        endcase
        i_grant = g;
        #1;
        pidx = -1;
        for (int i = 0; i < RW; i++) begin
            if (pidx < 0 && g[i] && e_req[i]) pidx = i;
        end
        accepted = v & e_rdy;
        if (pidx >= 0) begin
            sb.push_back({3'(pidx), mq[pidx].pop_front()});
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < RW; i++) begin
            if (accepted[i]) mq[i].push_back(dd[i]);
        end
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) step('0, '0, 1'b1, 2, '0, acc);
    endtask

    initial begin
        int nv, first, last, nx, gm;

        // Reset then idle
        do_reset();
        repeat (3) step('0, '0, 1'b0, 0, '0, acc);
        chk("idle_o_data", 32'(o_data), 32'd0);

        // Single port 3
        d = '0;
        d[3] = 16'hA5A5;
        step(8'h08, d, 1'b1, 0, '0, acc);
        step('0, '0, 1'b1, 1, 8'h08, acc);
        chk("single_request", 32'(o_request), 32'(8'h08));
        step('0, '0, 1'b1, 0, '0, acc);
        chk("single_valid",  32'(o_valid),  32'd1);
        chk("single_data",   32'(o_data),   32'(16'hA5A5));
        chk("single_source", 32'(o_source), 32'd3);
        step('0, '0, 1'b1, 0, '0, acc);
        chk("single_valid_clear", 32'(o_valid), 32'd0);

        // Full / backpressure on port 0
        for (int k = 0; k < 5; k++) begin
            d = '0;
            d[0] = 16'h0100 + 16'(k);
            step(8'h01, d, 1'b0, 0, '0, acc);
        end
        chk("full_ready0", 32'(o_ready[0]), 32'd0);
        step('0, '0, 1'b0, 1, 8'h01, acc);
        step('0, '0, 1'b0, 0, '0, acc);
        chk("bp_valid",   32'(o_valid),   32'd1);
        chk("bp_request", 32'(o_request), 32'd0);
        drain(10);

        // Round-robin drain, 2 entries per port
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < RW; p++) d[p] = 16'(p * 16 + k);
            step(8'hFF, d, 1'b1, 0, '0, acc);
        end
        first = -1;
        last  = -1;
        nx    = 0;
        for (int c = 0; c < 24; c++) begin
            step('0, '0, 1'b1, 2, '0, acc);
            if (o_valid === 1'b1) begin
                nx++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("rr_count", 32'(nx), 32'd16);
        chk("rr_span",  32'(last - first + 1), 32'd16);

        // Port 5 streaming with a continuous grant across pointer wraps
        nv = 0;
        for (int c = 0; c < 300 && nv < 64; c++) begin
            d = '0;
            d[5] = 16'h5000 + 16'(nv);
            step(8'h20, d, 1'b1, 1, 8'h20, acc);
            if (acc[5]) nv++;
        end
        chk("stream_pushed", 32'(nv), 32'd64);
        for (int c = 0; c < 6; c++) step('0, '0, 1'b1, 1, 8'h20, acc);
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            d = '0;
            d[2] = 16'h2200 + 16'(k);
            step(8'h04, d, 1'b0, 0, '0, acc);
        end
        step('0, '0, 1'b0, 1, 8'h04, acc);
        step('0, '0, 1'b0, 0, '0, acc);
        chk("midrst_valid_before", 32'(o_valid), 32'd1);
        do_reset();
        drain(8);
        chk("midrst_no_stale", 32'(o_valid), 32'd0);

`ifndef ARB_REQUEST_QUEUE_CHECK_EN
        // Multi-bit grant with a non-requesting bit: lowest qualifying port pops
        d = '0;
        d[1] = 16'h1111;
        d[2] = 16'h2222;
        step(8'h06, d, 1'b1, 0, '0, acc);
        step('0, '0, 1'b1, 1, 8'h86, acc);
        step('0, '0, 1'b1, 0, '0, acc);
        chk("illegal_grant_source", 32'(o_source), 32'd1);
        chk("illegal_grant_data",   32'(o_data),   32'(16'h1111));
        drain(6);
`endif

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < RW; p++) d[p] = 16'($urandom);
`ifdef ARB_REQUEST_QUEUE_CHECK_EN
            gm = $urandom_range(2, 3);
`else
            gm = $urandom_range(2, 4);
`endif
            step(RW'($urandom), d, ($urandom_range(0, 3) != 0), gm, '0, acc);
        end
        drain(60);
        chk("final_drained", 32'(sb.size()), 32'd0);
        chk("final_valid",   32'(o_valid),   32'd0);

`ifdef ARB_REQUEST_QUEUE_CHECK_EN
        // Illegal grant sets a sticky error
        step('0, '0, 1'b1, 1, 8'h03, acc);
        step('0, '0, 1'b1, 0, '0, acc);
        chk("error_set", 32'(o_error), 32'd1);
        repeat (3) step('0, '0, 1'b1, 0, '0, acc);
        chk("error_sticky", 32'(o_error), 32'd1);
        do_reset();
        chk("error_cleared", 32'(o_error), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
